// File: rtl/deserializer_pkg.sv
// Shared types and helpers for the streaming deserializer: accumulator state
// encoding, frame-length clamping and beat-to-word placement.
package deserializer_pkg;

  typedef enum logic [1:0] {
    ACC_EMPTY,
    ACC_FILLING,
    ACC_FULL
  } acc_state_e;

  // A length of zero or anything beyond the frame capacity means "full frame".
  function automatic int clamp_len(input int len, input int max_len);
    if (len <= 0 || len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

  // Beat k of a frame lands in word k (little-endian) or mirrored from the top.
  function automatic int word_slot(input int k, input int num_words, input int le);
    return (le != 0) ? k : (num_words - 1 - k);
  endfunction

endpackage

// File: rtl/deser_out_reg.sv
// One-entry valid/ready holding register for assembled frames. A load always
// wins; otherwise the entry empties when the consumer takes it. free tells the
// producer it may load this cycle (empty now, or being drained right now).
module deser_out_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [KEEP_W-1:0] keep,
  output logic              free
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [KEEP_W-1:0] keep_reg;

  assign free  = !valid_reg || ready;
  assign valid = valid_reg;
  assign data  = data_reg;
  assign keep  = keep_reg;

  // Hold the frame stable until it is taken; data stays put after a drain.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      keep_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      keep_reg  <= load_keep;
    end else if (ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/deserializer_stream.sv
// Streaming deserializer: packs WIDTH-bit beats into frames of up to NUM_WORDS
// words with a runtime length, early close (last/flush) and a keep mask. The
// accumulator can hold one closed frame while the output register holds
// another, so o_ready only depends on registered accumulator state.
module deserializer_stream
  import deserializer_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NUM_WORDS     = 4,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic                           clk,
  input  logic                           i_reset,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic                           i_last,
  input  logic                           i_flush,
  input  logic [$clog2(NUM_WORDS+1)-1:0] i_num_words,
  output logic [NUM_WORDS*WIDTH-1:0]     o_data,
  output logic [NUM_WORDS-1:0]           o_keep,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_busy
);

  localparam int LW = $clog2(NUM_WORDS + 1);
  localparam int FW = NUM_WORDS * WIDTH;

  acc_state_e           state_reg, state_next;
  logic [FW-1:0]        acc_data_reg, acc_data_next;
  logic [NUM_WORDS-1:0] acc_keep_reg, acc_keep_next;
  logic [LW-1:0]        count_reg, count_next;
  logic [LW-1:0]        len_reg, len_next;

  logic                 accept;
  logic [LW-1:0]        eff_len;
  logic                 last_beat;
  logic                 close;
  logic [NUM_WORDS-1:0] word_hit;
  logic [FW-1:0]        merged_data;
  logic [NUM_WORDS-1:0] merged_keep;

  logic                 out_free;
  logic                 out_load;
  logic [FW-1:0]        out_load_data;
  logic [NUM_WORDS-1:0] out_load_keep;

  assign o_ready = (state_reg != ACC_FULL) && !i_reset;
  assign accept  = i_valid && o_ready;

  // Length is taken from the input only on a frame's first beat.
  assign eff_len   = (state_reg == ACC_EMPTY)
                     ? LW'(clamp_len(int'(i_num_words), NUM_WORDS))
                     : len_reg;
  assign last_beat = (count_reg == eff_len - LW'(1));

  // A flush alone only closes a frame that already has beats in it.
  assign close = (accept && (last_beat || i_last)) ||
                 (i_flush && (accept || state_reg == ACC_FILLING));

  // Merge the incoming beat into its word slot; other words keep their value.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign word_hit[gi] = accept &&
                            (word_slot(int'(count_reg), NUM_WORDS, LITTLE_ENDIAN) == gi);
      assign merged_data[gi*WIDTH +: WIDTH] = word_hit[gi] ? i_data
                                            : acc_data_reg[gi*WIDTH +: WIDTH];
      assign merged_keep[gi] = word_hit[gi] || acc_keep_reg[gi];
    end
  endgenerate

  // Accumulator next-state: fill, close, and hand frames to the output register.
  always_comb begin
    state_next    = state_reg;
    acc_data_next = acc_data_reg;
    acc_keep_next = acc_keep_reg;
    count_next    = count_reg;
    len_next      = len_reg;
    out_load      = 1'b0;
    out_load_data = merged_data;
    out_load_keep = merged_keep;

    case (state_reg)
      ACC_EMPTY, ACC_FILLING: begin
        if (accept) begin
          acc_data_next = merged_data;
          acc_keep_next = merged_keep;
          count_next    = count_reg + LW'(1);
          len_next      = eff_len;
          state_next    = ACC_FILLING;
        end
        if (close) begin
          count_next = '0;
          if (out_free) begin
            out_load      = 1'b1;
            acc_data_next = '0;
            acc_keep_next = '0;
            state_next    = ACC_EMPTY;
          end else begin
            acc_data_next = merged_data;
            acc_keep_next = merged_keep;
            state_next    = ACC_FULL;
          end
        end
      end
      ACC_FULL: begin
        if (out_free) begin
          out_load      = 1'b1;
          out_load_data = acc_data_reg;
          out_load_keep = acc_keep_reg;
          acc_data_next = '0;
          acc_keep_next = '0;
          state_next    = ACC_EMPTY;
        end
      end
      default: begin
        state_next = ACC_EMPTY;
      end
    endcase
  end

  // Accumulator state register; reset discards any partial or held frame.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_reg    <= ACC_EMPTY;
      acc_data_reg <= '0;
      acc_keep_reg <= '0;
      count_reg    <= '0;
      len_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      acc_data_reg <= acc_data_next;
      acc_keep_reg <= acc_keep_next;
      count_reg    <= count_next;
      len_reg      <= len_next;
    end
  end

  deser_out_reg #(
    .DATA_W(FW),
    .KEEP_W(NUM_WORDS)
  ) u_out_reg (
    .clk      (clk),
    .i_reset  (i_reset),
    .load     (out_load),
    .load_data(out_load_data),
    .load_keep(out_load_keep),
    .ready    (i_ready),
    .valid    (o_valid),
    .data     (o_data),
    .keep     (o_keep),
    .free     (out_free)
  );

  assign o_busy = (state_reg != ACC_EMPTY) || o_valid;

endmodule

// File: tb/tb_deserializer_stream.sv
// Bench for deserializer_stream: a little-endian and a big-endian instance
// share one stimulus stream. A frame-queue model predicts every output each
// cycle; directed scenarios also pin hand-computed frames.
module tb_deserializer_stream;

  logic        clk;
  logic        i_reset;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_last;
  logic        i_flush;
  logic [2:0]  i_num_words;
  logic        i_ready;

  logic        ready_le, valid_le, busy_le;
  logic [31:0] data_le;
  logic [3:0]  keep_le;
  logic        ready_be, valid_be, busy_be;
  logic [31:0] data_be;
  logic [3:0]  keep_be;

  int n_vec = 0;
  int n_bad = 0;

  deserializer_stream #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(1)) dut_le (
    .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .o_ready(ready_le),
    .i_last(i_last), .i_flush(i_flush), .i_num_words(i_num_words), .o_data(data_le),
    .o_keep(keep_le), .o_valid(valid_le), .i_ready(i_ready), .o_busy(busy_le)
  );

  deserializer_stream #(.WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(0)) dut_be (
    .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .o_ready(ready_be),
    .i_last(i_last), .i_flush(i_flush), .i_num_words(i_num_words), .o_data(data_be),
    .o_keep(keep_be), .o_valid(valid_be), .i_ready(i_ready), .o_busy(busy_be)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- model: closed frames waiting downstream + open frame ----------------
  logic [31:0] q_le_data[$];
  logic [3:0]  q_le_keep[$];
  logic [31:0] q_be_data[$];
  logic [3:0]  q_be_keep[$];
  logic [31:0] cur_le_data, cur_be_data;
  logic [3:0]  cur_le_keep, cur_be_keep;
  int          m_cnt;
  int          m_len;
  bit          started = 1'b0;

  initial begin
    bit ready_m;
    bit acc;
    cur_le_data = '0; cur_be_data = '0; cur_le_keep = '0; cur_be_keep = '0;
    m_cnt = 0; m_len = 4;
    forever begin
      @(posedge clk);
      if (i_reset) begin
        q_le_data.delete(); q_le_keep.delete(); q_be_data.delete(); q_be_keep.delete();
        cur_le_data = '0; cur_be_data = '0; cur_le_keep = '0; cur_be_keep = '0;
        m_cnt = 0;
        started = 1'b1;
      end else if (started) begin
        // Room for one frame downstream plus one parked in the accumulator.
        ready_m = (q_le_data.size() < 2);
        if (q_le_data.size() > 0 && i_ready) begin
          void'(q_le_data.pop_front()); void'(q_le_keep.pop_front());
          void'(q_be_data.pop_front()); void'(q_be_keep.pop_front());
        end
        acc = i_valid && ready_m;
        if (acc) begin
          if (m_cnt == 0) m_len = (i_num_words == 0 || i_num_words > 4) ? 4 : int'(i_num_words);
          cur_le_data[m_cnt*8 +: 8]     = i_data;
          cur_le_keep[m_cnt]            = 1'b1;
          cur_be_data[(3-m_cnt)*8 +: 8] = i_data;
          cur_be_keep[3-m_cnt]          = 1'b1;
          m_cnt++;
        end
        if ((acc && (m_cnt == m_len || i_last)) || (i_flush && m_cnt > 0)) begin
          q_le_data.push_back(cur_le_data); q_le_keep.push_back(cur_le_keep);
          q_be_data.push_back(cur_be_data); q_be_keep.push_back(cur_be_keep);
          cur_le_data = '0; cur_be_data = '0; cur_le_keep = '0; cur_be_keep = '0;
          m_cnt = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare on the falling edge ----------------
  initial begin
    bit e_ready, e_valid, e_busy;
    forever begin
      @(negedge clk);
      if (started) begin
        e_ready = !i_reset && (q_le_data.size() < 2);
        e_valid = (q_le_data.size() > 0);
        e_busy  = (q_le_data.size() > 0) || (m_cnt > 0);
        check("o_ready_le", {31'd0, ready_le}, {31'd0, e_ready});
        check("o_ready_be", {31'd0, ready_be}, {31'd0, e_ready});
        check("o_valid_le", {31'd0, valid_le}, {31'd0, e_valid});
        check("o_valid_be", {31'd0, valid_be}, {31'd0, e_valid});
        check("o_busy_le",  {31'd0, busy_le},  {31'd0, e_busy});
        check("o_busy_be",  {31'd0, busy_be},  {31'd0, e_busy});
        if (e_valid) begin
          check("o_data_le", data_le, q_le_data[0]);
          check("o_keep_le", {28'd0, keep_le}, {28'd0, q_le_keep[0]});
          check("o_data_be", data_be, q_be_data[0]);
          check("o_keep_be", {28'd0, keep_be}, {28'd0, q_be_keep[0]});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] nw, input logic last, input logic fl);
    int  t;
    bit  done;
    logic r;
    i_data = d; i_num_words = nw; i_last = last; i_flush = fl; i_valid = 1'b1;
    t = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      r = ready_le;
      @(posedge clk);
      #1;
      if (r === 1'b1) begin
        done = 1'b1;
      end else begin
        t++;
        if (t > 50) begin
          n_vec++; n_bad++;
          $display("FAIL send_timeout: beat %h never accepted", d);
          done = 1'b1;
        end
      end
    end
    i_valid = 1'b0; i_last = 1'b0; i_flush = 1'b0;
  endtask

  task automatic flush_pulse();
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
  endtask

  // Frame expected on the output in the cycle right after the closing edge.
  task automatic expect_frame(input string name, input logic [31:0] dle, input logic [3:0] kle,
                              input logic [31:0] dbe, input logic [3:0] kbe);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, valid_le}, 32'd1);
    check({name, "_data_le"}, data_le, dle);
    check({name, "_keep_le"}, {28'd0, keep_le}, {28'd0, kle});
    check({name, "_data_be"}, data_be, dbe);
    check({name, "_keep_be"}, {28'd0, keep_be}, {28'd0, kbe});
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bit [9:0] pat;
    i_reset = 1'b1; i_data = '0; i_valid = 1'b0; i_last = 1'b0; i_flush = 1'b0;
    i_num_words = 3'd4; i_ready = 1'b1;

    // Reset state
    idle(2);
    @(negedge clk);
    check("rst_ready", {31'd0, ready_le}, 32'd0);
    check("rst_valid", {31'd0, valid_le}, 32'd0);
    check("rst_data",  data_le, 32'd0);
    check("rst_keep",  {28'd0, keep_le}, 32'd0);
    check("rst_busy",  {31'd0, busy_le}, 32'd0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    check("rst_ready_after", {31'd0, ready_le}, 32'd1);
    @(posedge clk); #1;

    // Full little/big-endian frame, output one cycle after the last beat
    send(8'h11, 3'd4, 1'b0, 1'b0);
    send(8'h22, 3'd4, 1'b0, 1'b0);
    send(8'h33, 3'd4, 1'b0, 1'b0);
    send(8'h44, 3'd4, 1'b0, 1'b0);
    expect_frame("full", 32'h44332211, 4'b1111, 32'h11223344, 4'b1111);

    // Short frame closed by i_last
    send(8'hAA, 3'd4, 1'b0, 1'b0);
    send(8'hBB, 3'd4, 1'b1, 1'b0);
    expect_frame("last", 32'h0000BBAA, 4'b0011, 32'hAABB0000, 4'b1100);

    // Backpressure: two frames pile up, accumulator full stops input
    i_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 3'd4, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ready_low", {31'd0, ready_le}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_data", data_le, 32'h13121110);
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_frame1", data_le, 32'h13121110);
    @(negedge clk);
    check("bp_frame2", data_le, 32'h17161514);
    @(posedge clk); #1;

    // Length latched on first beat; change mid-frame is ignored
    send(8'h01, 3'd2, 1'b0, 1'b0);
    send(8'h02, 3'd3, 1'b0, 1'b0);
    expect_frame("len2", 32'h00000201, 4'b0011, 32'h01020000, 4'b1100);
    send(8'h03, 3'd3, 1'b0, 1'b0);
    send(8'h04, 3'd3, 1'b0, 1'b0);
    send(8'h05, 3'd3, 1'b0, 1'b0);
    expect_frame("len3", 32'h00050403, 4'b0111, 32'h03040500, 4'b1110);

    // Flush alone closes a partial frame; flush with nothing pending is a no-op
    send(8'h5A, 3'd4, 1'b0, 1'b0);
    flush_pulse();
    expect_frame("flush", 32'h0000005A, 4'b0001, 32'h5A000000, 4'b1000);
    idle(1);
    flush_pulse();
    @(negedge clk);
    check("flush_empty_novalid", {31'd0, valid_le}, 32'd0);
    @(posedge clk); #1;

    // Flush on the same cycle as a beat includes that beat
    send(8'h61, 3'd4, 1'b0, 1'b0);
    send(8'h62, 3'd4, 1'b0, 1'b1);
    expect_frame("flush_beat", 32'h00006261, 4'b0011, 32'h61620000, 4'b1100);

    // Length 0 and length > NUM_WORDS both mean a full frame
    for (int i = 0; i < 4; i++) send(8'h91 + 8'(i), 3'd0, 1'b0, 1'b0);
    expect_frame("len0", 32'h94939291, 4'b1111, 32'h91929394, 4'b1111);
    for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), 3'd7, 1'b0, 1'b0);
    expect_frame("len7", 32'hA4A3A2A1, 4'b1111, 32'hA1A2A3A4, 4'b1111);

    // Reset mid-frame drops the partial frame
    send(8'h71, 3'd4, 1'b0, 1'b0);
    send(8'h72, 3'd4, 1'b0, 1'b0);
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy_le}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(8'h81 + 8'(i), 3'd4, 1'b0, 1'b0);
    expect_frame("midrst", 32'h84838281, 4'b1111, 32'h81828384, 4'b1111);

    // Mixed stream with a fixed ready pattern, checked by the model
    pat = 10'b1011001101;
    for (int i = 0; i < 10; i++) begin
      i_ready = pat[i];
      send(8'hC0 + 8'(i), 3'd3, (i == 6) ? 1'b1 : 1'b0, 1'b0);
    end
    i_ready = 1'b1;
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
